// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache line fill path: address field
// positions, line geometry and the fill FSM state encoding.
package icache_pkg;

    localparam int ADDR_W    = 32;
    localparam int TAG_W     = 19;
    localparam int INDEX_W   = 7;
    localparam int BEATS     = 4;
    localparam int BEAT_W    = 2;
    localparam int WAY_W     = 2;
    localparam int DATA_W    = 128;
    localparam int LINE_W    = 6;

    localparam int TAG_LSB   = 13;
    localparam int INDEX_LSB = 6;
    localparam int BEAT_LSB  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/icache_fill_controller.sv
// Refills one 64-byte I-cache line after a lookup miss: one line-read request,
// four 16-byte response beats, each written into the cache one cycle later.
module icache_fill_controller
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 lookup_valid,
    input  logic [ADDR_W-1:0]    lookup_addr,
    input  logic                 lookup_hit,
    input  logic [WAY_W-1:0]     lookup_way,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,

    input  logic                 mem_resp_valid,
    input  logic [DATA_W-1:0]    mem_resp_data,

    output logic                 w,
    output logic [INDEX_W-1:0]   w_index,
    output logic [TAG_W-1:0]     w_tag,
    output logic [LINE_W-1:0]    w_line,
    output logic [DATA_W-1:0]    w_data,
    output logic [WAY_W-1:0]     w_way,

    output logic                 stall,
    output logic                 fill_done,
    output logic [31:0]          miss_count,
    output logic                 proto_err
);

    fill_state_e                 state_q, state_d;
    logic [ADDR_W-1:INDEX_LSB]   line_addr_q, line_addr_d;
    logic [WAY_W-1:0]            way_q, way_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [31:0]                 miss_count_q, miss_count_d;
    logic                        req_valid_q, req_valid_d;
    logic                        fill_done_q, fill_done_d;
    logic                        proto_err_q, proto_err_d;
    logic                        w_q, w_d;
    logic [LINE_W-1:0]           w_line_q, w_line_d;
    logic [DATA_W-1:0]           w_data_q, w_data_d;

    // The line read always starts at beat 0, so the offset bits are never stored.
    logic                        unused_offset;
    assign unused_offset = ^lookup_addr[INDEX_LSB-1:0];

    logic miss;
    assign miss = lookup_valid & ~lookup_hit;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        way_d        = way_q;
        beat_d       = beat_q;
        miss_count_d = miss_count_q;
        req_valid_d  = req_valid_q;
        fill_done_d  = 1'b0;
        w_d          = 1'b0;
        w_line_d     = w_line_q;
        w_data_d     = w_data_q;
        proto_err_d  = proto_err_q | (mem_resp_valid & (state_q != S_FILL));

        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    line_addr_d  = lookup_addr[ADDR_W-1:INDEX_LSB];
                    way_d        = lookup_way;
                    miss_count_d = (miss_count_q == '1) ? miss_count_q : miss_count_q + 32'd1;
                    req_valid_d  = 1'b1;
                    state_d      = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    beat_d      = '0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_resp_valid) begin
                    w_d      = 1'b1;
                    w_data_d = mem_resp_data;
                    w_line_d = {beat_q, 4'b0000};
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        fill_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the async reset also kills any in-flight write pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            line_addr_q  <= '0;
            way_q        <= '0;
            beat_q       <= '0;
            miss_count_q <= '0;
            req_valid_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            proto_err_q  <= 1'b0;
            w_q          <= 1'b0;
            w_line_q     <= '0;
            w_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            way_q        <= way_d;
            beat_q       <= beat_d;
            miss_count_q <= miss_count_d;
            req_valid_q  <= req_valid_d;
            fill_done_q  <= fill_done_d;
            proto_err_q  <= proto_err_d;
            w_q          <= w_d;
            w_line_q     <= w_line_d;
            w_data_q     <= w_data_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = {line_addr_q, {INDEX_LSB{1'b0}}};
    assign w             = w_q;
    assign w_index       = line_addr_q[TAG_LSB-1:INDEX_LSB];
    assign w_tag         = line_addr_q[ADDR_W-1:TAG_LSB];
    assign w_line        = w_line_q;
    assign w_data        = w_data_q;
    assign w_way         = way_q;
    assign fill_done     = fill_done_q;
    assign miss_count    = miss_count_q;
    assign proto_err     = proto_err_q;

    // Hold the fetch from the very cycle the miss is seen until the fill retires.
    assign stall = (state_q != S_IDLE) | miss;

endmodule

// File: tb/tb_icache_fill_controller.sv
// Directed bench for icache_fill_controller: stimulus pushes expected requests
// and cache writes into queues, a negedge monitor pops and compares them.
module tb_icache_fill_controller;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lookup_valid = 1'b0;
    logic [31:0]  lookup_addr = '0;
    logic         lookup_hit = 1'b0;
    logic [1:0]   lookup_way = '0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;
    logic         w;
    logic [6:0]   w_index;
    logic [18:0]  w_tag;
    logic [5:0]   w_line;
    logic [127:0] w_data;
    logic [1:0]   w_way;
    logic         stall;
    logic         fill_done;
    logic [31:0]  miss_count;
    logic         proto_err;

    icache_fill_controller dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_valid   (lookup_valid),
        .lookup_addr    (lookup_addr),
        .lookup_hit     (lookup_hit),
        .lookup_way     (lookup_way),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .w              (w),
        .w_index        (w_index),
        .w_tag          (w_tag),
        .w_line         (w_line),
        .w_data         (w_data),
        .w_way          (w_way),
        .stall          (stall),
        .fill_done      (fill_done),
        .miss_count     (miss_count),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   index;
        logic [18:0]  tag;
        logic [5:0]   line;
        logic [127:0] data;
        logic [1:0]   way;
        logic         done;
    } exp_w_t;

    exp_w_t       exp_w_q[$];
    logic [31:0]  exp_req_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_miss = '0;
    logic         exp_proto = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write pulse and request cycle against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (w) begin
                if (exp_w_q.size() == 0) begin
                    check("unexpected_w", 1, 0);
                end else begin
                    exp_w_t e;
                    e = exp_w_q.pop_front();
                    check("w_index",   w_index,   e.index);
                    check("w_tag",     w_tag,     e.tag);
                    check("w_line",    w_line,    e.line);
                    check("w_data",    w_data,    e.data);
                    check("w_way",     w_way,     e.way);
                    check("fill_done", fill_done, e.done);
                end
            end else if (fill_done) begin
                check("fill_done_without_w", 1, 0);
            end
            if (mem_req_valid) begin
                if (exp_req_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    check("mem_req_addr", mem_req_addr, exp_req_q[0]);
                    if (mem_req_ready) void'(exp_req_q.pop_front());
                end
            end
        end
    end

    task automatic wait_drained();
        for (int i = 0; i < 20 && (exp_w_q.size() + exp_req_q.size()) != 0; i++)
            @(posedge clk);
        check("drain_timeout", exp_w_q.size() + exp_req_q.size(), 0);
    endtask

    // One complete miss/refill; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_fill(input logic [31:0] addr, input logic [1:0] way,
                            input logic [6:0] e_index, input logic [18:0] e_tag,
                            input logic [31:0] e_req, input logic [31:0] base,
                            input int ready_delay, input int gap0, input int gap2,
                            input bit extra_miss);
        int gaps[4];
        gaps[0] = gap0; gaps[1] = 0; gaps[2] = gap2; gaps[3] = 0;
        exp_miss = exp_miss + 32'd1;
        exp_req_q.push_back(e_req);
        for (int b = 0; b < 4; b++) begin
            exp_w_t e;
            e.index = e_index; e.tag = e_tag; e.line = 6'(b * 16);
            e.data = {4{base + 32'(b)}}; e.way = way; e.done = (b == 3);
            exp_w_q.push_back(e);
        end
        lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = addr; lookup_way = way;
        @(negedge clk);
        check("stall_on_miss", stall, 1);
        @(posedge clk); #1;
        lookup_valid = 1'b0;
        mem_req_ready = (ready_delay == 0);
        for (int i = 0; i < ready_delay; i++) begin
            if (extra_miss && i == 1) begin
                lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'hDEAD_BEC0; lookup_way = 2'd1;
            end
            @(negedge clk);
            check("req_valid_held", mem_req_valid, 1);
            check("stall_in_req", stall, 1);
            @(posedge clk); #1;
            lookup_valid = 1'b0;
        end
        if (ready_delay > 0) mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = {4{base + 32'(b)}};
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            for (int g = 0; g < gaps[b]; g++) begin
                @(negedge clk);
                check("stall_in_gap", stall, 1);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("done_pulse", fill_done, 1);
        check("miss_count", miss_count, exp_miss);
        check("stall_in_done", stall, 1);
        check("proto_err", proto_err, exp_proto);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_after_done", stall, 0);
        check("req_idle", mem_req_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_w", w, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_miss_count", miss_count, 0);
        check("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic miss: ready immediately, consecutive beats.
        run_fill(32'h0000_2A40, 2'd2, 7'h29, 19'h1, 32'h0000_2A40, 32'hD000_0000, 0, 0, 0, 1'b0);
        // Back-to-back miss, ready held low 5 cycles, a second miss ignored meanwhile.
        run_fill(32'h1234_5680, 2'd0, 7'h5A, 19'h091A2, 32'h1234_5680, 32'hA000_0010, 5, 0, 0, 1'b1);
        wait_drained();

        // Hit in IDLE: no stall, no request, count unchanged.
        @(posedge clk); #1;
        lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_addr = 32'h1000_0000; lookup_way = 2'd1;
        @(negedge clk);
        check("hit_stall", stall, 0);
        @(posedge clk); #1;
        lookup_valid = 1'b0; lookup_hit = 1'b0;
        @(negedge clk);
        check("hit_no_req", mem_req_valid, 0);
        check("hit_miss_count", miss_count, exp_miss);
        @(posedge clk); #1;

        // Gaps of 2 cycles after beats 0 and 2; top-of-memory line, way 3.
        run_fill(32'hFFFF_FFC4, 2'd3, 7'h7F, 19'h7FFFF, 32'hFFFF_FFC0, 32'hB000_0020, 1, 2, 2, 1'b0);
        wait_drained();

        // Stray response beat in IDLE: sticky protocol error, no write.
        @(posedge clk); #1;
        mem_resp_valid = 1'b1; mem_resp_data = {4{32'hBAD0_BAD0}};
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        exp_proto = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("proto_err_sticky", proto_err, 1);
            check("proto_no_w", w, 0);
        end
        @(posedge clk); #1;

        // Reset while the beat-1 write is on the port.
        exp_req_q.push_back(32'h0000_2A40);
        begin
            exp_w_t e;
            e.index = 7'h29; e.tag = 19'h1; e.line = 6'h00;
            e.data = {4{32'hC000_0000}}; e.way = 2'd1; e.done = 1'b0;
            exp_w_q.push_back(e);
        end
        lookup_valid = 1'b1; lookup_hit = 1'b0; lookup_addr = 32'h0000_2A40; lookup_way = 2'd1;
        @(posedge clk); #1;
        lookup_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {4{32'hC000_0000}};
        @(posedge clk); #1;
        mem_resp_data = {4{32'hC000_0001}};
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_kills_w", w, 0);
        check("rst_mid_req_valid", mem_req_valid, 0);
        check("rst_mid_miss_count", miss_count, 0);
        check("rst_mid_proto_err", proto_err, 0);
        @(negedge clk);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_queue", exp_w_q.size(), 0);
        @(posedge clk); #1;
        check("rst_hold_w", w, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_miss = '0;
        exp_proto = 1'b0;
        @(posedge clk); #1;

        // Fresh fill after reset restarts at beat 0.
        run_fill(32'h0000_0070, 2'd1, 7'h01, 19'h0, 32'h0000_0040, 32'hE000_0000, 0, 0, 0, 1'b0);
        wait_drained();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
